btb_fetch: RTL and testbench
============================

# btb_fetch

Fetch-stage next-PC generator built around a direct-mapped branch target buffer (BTB). It holds the fetch PC and supplies the gshare predictor's read index. It combines the gshare direction bit with the BTB target to choose the next PC. It receives resolved branches from EX, detects mispredicts, redirects fetch, and drives the gshare update port. It sits directly upstream of the gshare predictor (producing its read and write addresses) and consumes its prediction.

## Interface
Parameters:
- ENTRIES, 32: BTB entries (power of two)
- IDX_W, 5: log2(ENTRIES); also gshare index width
- RESET_PC, 32'h0000_0000: fetch PC after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold fetch PC (IF/ID back-pressure)
- pc  out  32  current fetch PC
- gs_raddr  out  IDX_W  pc[IDX_W+1:2], to gshare read address
- gs_taken  in  1  gshare direction prediction for gs_raddr
- pred_taken  out  1  prediction travelling with pc
- pred_target  out  32  predicted target travelling with pc
- ex_valid  in  1  EX resolved a control-flow instruction this cycle
- ex_is_br  in  1  1 = conditional branch, 0 = jal/jalr
- ex_pc, ex_target, ex_pred_target  in  32  resolved PC, actual target, target predicted at fetch
- ex_taken, ex_pred_taken  in  1  actual and predicted direction
- redirect  out  1  mispredict; pipeline flushes IF/ID/EX-younger
- gs_we, gs_br_taken  out  1  gshare update strobe and outcome
- gs_waddr  out  IDX_W  ex_pc[IDX_W+1:2]
- mispredict_cnt  out  32  mispredicts since reset

## Operation
- Lookup: idx = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]. hit = valid[idx] & tag match.
- Entry fields: valid, tag, target[31:2], kind (1 = unconditional).
- pred_taken = hit & (kind | gs_taken). pred_target = {target, 2'b00} when hit, else pc+4.
- Mispredict = ex_valid & ((ex_taken != ex_pred_taken) | (ex_taken & ex_target != ex_pred_target)).
- redirect = Mispredict, combinational from EX inputs.
- Correct PC = ex_taken ? ex_target : ex_pc+4, with bits [1:0] forced to 0.
- Next-PC priority:
  - redirect: correct PC
  - else stall: pc
  - else pred_taken: pred_target
  - else pc+4
- redirect overrides stall.
- BTB write when ex_valid & ex_taken: at idx(ex_pc) write tag(ex_pc), ex_target[31:2], kind = !ex_is_br, valid = 1. This always replaces the entry.
- Not-taken branches do not write; the entry is kept and direction is left to gshare.
- gs_we = ex_valid & ex_is_br. gs_br_taken = ex_taken. Jumps never update gshare.
- mispredict_cnt increments by 1 per mispredict cycle and wraps at 2^32.
- Arithmetic: all PC adds are modulo 2^32, so 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset, asynchronous and effective mid-operation:
  - pc = RESET_PC
  - all valid = 0
  - mispredict_cnt = 0
  - tag/target contents undefined
- Outputs during reset: pred_taken = 0, pred_target = RESET_PC+4.
- Lookup is combinational. pc, gs_raddr, pred_* are valid in the same cycle; gshare read is combinational.
- redirect, gs_we, gs_waddr, gs_br_taken are combinational from EX inputs in the same cycle. gshare latches the update on that edge.
- pc updates one edge after redirect.
- BTB write lands at the edge. A same-cycle lookup of the same index sees the old contents; the following cycle sees the new contents.
- First cycle after reset deassertion fetches RESET_PC.

## Structure
- Package btb_pkg holds:
  - XLEN = 32
  - IDX_W
  - RESET_PC
  - btb_entry_t struct {valid, tag, target[31:2], kind}
  - function idx_of(pc) / tag_of(pc)
- Sub-module btb_ram:
  - ENTRIES × btb_entry_t storage
  - asynchronous-reset valid vector
  - one combinational read port, one synchronous write port
- btb_fetch holds the PC register, next-PC mux, mispredict logic and counter.

## Test plan
- Reset then run 3 cycles without stall: pc = 0, 4, 8; pred_taken = 0; mispredict_cnt = 0.
- Pulse rst while pc = 0x40: pc reads 0 immediately, before any clock edge; earlier BTB entries no longer hit.
- Jump at 0x10 to 0x100 resolved in EX with ex_pred_taken = 0: redirect = 1, next pc = 0x100, mispredict_cnt = 1, gs_we = 0. Next fetch of 0x10 gives pred_taken = 1, pred_target = 0x100 with gs_taken = 0.
- Branch at 0x20 to 0x80 in BTB with gs_taken = 1: pred_taken = 1, next pc = 0x80. EX resolves not taken: redirect, pc = 0x24, gs_we = 1, gs_waddr = 8, gs_br_taken = 0.
- Redirect and stall in the same cycle: redirect wins, pc = correct PC. Plain stall holds pc for 2 cycles.
- Aliasing: 0x0 and 0x80 share idx 0 with different tags. A taken write from 0x80 evicts 0x0; fetch of 0x0 misses (pred_taken = 0).

Source files
------------

// File: rtl/btb_pkg.sv
// btb_pkg: shared widths, reset PC, BTB entry layout and PC index/tag helpers
package btb_pkg;
  localparam int XLEN = 32;
  localparam int IDX_W = 5;
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-3:0] target;
    logic kind;
  } btb_entry_t;
  function automatic logic [IDX_W-1:0] idx_of(input logic [XLEN-1:0] a);
    return a[IDX_W+1:2];
  endfunction
  function automatic logic [TAG_W-1:0] tag_of(input logic [XLEN-1:0] a);
    return a[XLEN-1:IDX_W+2];
  endfunction
endpackage

// File: rtl/btb_ram.sv
// btb_ram: direct-mapped BTB storage, async-cleared valid bits, comb read, sync write
module btb_ram
  import btb_pkg::*;
#(
  parameter int ENTRIES = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(ENTRIES)-1:0] raddr,
  output btb_entry_t                 rdata,
  input  logic                       we,
  input  logic [$clog2(ENTRIES)-1:0] waddr,
  input  btb_entry_t                 wdata
);
  btb_entry_t mem [ENTRIES];
  logic [ENTRIES-1:0] valid_q;
  // valid bits are the only state reset clears; payload is left undefined
  always_ff @(posedge clk or posedge rst)
    if (rst) valid_q <= '0;
    else if (we) valid_q[waddr] <= 1'b1;
  // payload write; a same-cycle read still returns the old entry
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // combinational read gated by the resettable valid vector
  always_comb begin
    rdata = mem[raddr];
    rdata.valid = valid_q[raddr] & mem[raddr].valid;
  end
endmodule

// File: rtl/btb_fetch.sv
// btb_fetch: fetch PC register, BTB/gshare next-PC selection, EX mispredict redirect
module btb_fetch
  import btb_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int IDX_W = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  output logic [31:0]      pc,
  output logic [IDX_W-1:0] gs_raddr,
  input  logic             gs_taken,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             ex_valid,
  input  logic             ex_is_br,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic [31:0]      ex_pred_target,
  input  logic             ex_taken,
  input  logic             ex_pred_taken,
  output logic             redirect,
  output logic             gs_we,
  output logic             gs_br_taken,
  output logic [IDX_W-1:0] gs_waddr,
  output logic [31:0]      mispredict_cnt
);
  btb_entry_t rd, wd;
  logic hit, btb_we;
  logic [31:0] pc_plus4, correct_pc, next_pc;
  assign gs_raddr = idx_of(pc);
  assign gs_waddr = idx_of(ex_pc);
  assign btb_we = ex_valid & ex_taken;
  btb_ram #(.ENTRIES(ENTRIES)) u_ram (
    .clk(clk), .rst(rst), .raddr(gs_raddr), .rdata(rd),
    .we(btb_we), .waddr(gs_waddr), .wdata(wd)
  );
  // lookup, resolution and next-PC priority: redirect > stall > predicted > sequential
  always_comb begin
    hit = rd.valid && (rd.tag == tag_of(pc));
    pc_plus4 = pc + 32'd4;
    pred_taken = hit & (rd.kind | gs_taken);
    pred_target = hit ? {rd.target, 2'b00} : pc_plus4;
    redirect = ex_valid & ((ex_taken != ex_pred_taken) | (ex_taken & (ex_target != ex_pred_target)));
    correct_pc = (ex_taken ? ex_target : ex_pc + 32'd4) & ~32'd3;
    next_pc = redirect ? correct_pc : stall ? pc : pred_taken ? pred_target : pc_plus4;
    gs_we = ex_valid & ex_is_br;
    gs_br_taken = ex_taken;
    wd = '{valid: 1'b1, tag: tag_of(ex_pc), target: ex_target[31:2], kind: ~ex_is_br};
  end
  // fetch PC and mispredict counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_PC;
      mispredict_cnt <= '0;
    end else begin
      pc <= next_pc;
      mispredict_cnt <= mispredict_cnt + {31'd0, redirect};
    end
endmodule

// File: tb/tb_btb_fetch.sv
// tb_btb_fetch: directed scoreboard bench for the BTB fetch next-PC generator
module tb_btb_fetch;
  logic clk = 0, rst = 1, stall = 0, gs_taken = 0;
  logic ex_valid = 0, ex_is_br = 0, ex_taken = 0, ex_pred_taken = 0;
  logic [31:0] ex_pc = 0, ex_target = 0, ex_pred_target = 0;
  logic [31:0] pc, pred_target, mispredict_cnt;
  logic [4:0] gs_raddr, gs_waddr;
  logic pred_taken, redirect, gs_we, gs_br_taken;
  int checks = 0, failures = 0;
  typedef struct { string name; logic [31:0] exp; } sb_t;
  sb_t sbq[$];

  btb_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .pc(pc), .gs_raddr(gs_raddr), .gs_taken(gs_taken),
    .pred_taken(pred_taken), .pred_target(pred_target), .ex_valid(ex_valid), .ex_is_br(ex_is_br),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_target(ex_pred_target), .ex_taken(ex_taken),
    .ex_pred_taken(ex_pred_taken), .redirect(redirect), .gs_we(gs_we), .gs_br_taken(gs_br_taken),
    .gs_waddr(gs_waddr), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs(input string n);
    if (n == "pc") return pc;
    if (n == "pred_taken") return 32'(pred_taken);
    if (n == "pred_target") return pred_target;
    if (n == "cnt") return mispredict_cnt;
    if (n == "redirect") return 32'(redirect);
    if (n == "gs_we") return 32'(gs_we);
    if (n == "gs_waddr") return 32'(gs_waddr);
    if (n == "gs_raddr") return 32'(gs_raddr);
    if (n == "gs_br_taken") return 32'(gs_br_taken);
    return 'x;
  endfunction

  task automatic push(input string n, input logic [31:0] v);
    sbq.push_back('{n, v});
  endtask

  task automatic drain();
    sb_t e;
    logic [31:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = obs(e.name);
      checks++;
      assert (o === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.name, o, e.exp);
      end
    end
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic set_ex(input logic br, input logic [31:0] p, input logic [31:0] t,
                        input logic tk, input logic ptk, input logic [31:0] pt);
    ex_valid = 1; ex_is_br = br; ex_pc = p; ex_target = t;
    ex_taken = tk; ex_pred_taken = ptk; ex_pred_target = pt;
  endtask

  task automatic clr_ex();
    ex_valid = 0; ex_is_br = 0; ex_taken = 0; ex_pred_taken = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    push("pc", 0); push("pred_taken", 0); push("pred_target", 4); push("cnt", 0); push("redirect", 0);
    settle();
    @(posedge clk); #3; rst = 0;
    push("pc", 0); settle();
    push("pc", 4); step();
    push("pc", 8); push("pred_taken", 0); push("cnt", 0); step();
    // unpredicted jump 0x10 -> 0x100
    set_ex(0, 32'h10, 32'h100, 1, 0, 32'h14);
    push("redirect", 1); push("gs_we", 0); settle();
    push("pc", 32'h100); push("cnt", 1); step();
    // branch at 0xC predicted taken, actually not taken: back to 0x10
    set_ex(1, 32'hC, 32'h40, 0, 1, 32'h40);
    push("redirect", 1); push("gs_we", 1); push("gs_waddr", 3); push("gs_br_taken", 0); settle();
    push("pc", 32'h10); push("cnt", 2); step();
    clr_ex(); gs_taken = 0;
    push("pred_taken", 1); push("pred_target", 32'h100); push("gs_raddr", 4); settle();
    push("pc", 32'h100); step();
    // correctly predicted taken branch 0x20 -> 0x80 installs a BTB entry
    set_ex(1, 32'h20, 32'h80, 1, 1, 32'h80);
    push("redirect", 0); push("gs_we", 1); push("gs_waddr", 8); push("gs_br_taken", 1); settle();
    push("pc", 32'h104); step();
    // redirect and stall together: redirect wins
    stall = 1; set_ex(0, 32'h50, 32'h20, 1, 0, 32'h54);
    push("redirect", 1); settle();
    push("pc", 32'h20); push("cnt", 3); step();
    clr_ex(); stall = 0;
    push("pred_taken", 0); push("pred_target", 32'h80); push("gs_raddr", 8); settle();
    gs_taken = 1;
    push("pred_taken", 1); push("pred_target", 32'h80); settle();
    push("pc", 32'h80); step();
    // branch at 0x20 resolves not taken
    set_ex(1, 32'h20, 32'h80, 0, 1, 32'h80);
    push("redirect", 1); push("gs_we", 1); push("gs_waddr", 8); push("gs_br_taken", 0); settle();
    push("pc", 32'h24); push("cnt", 4); step();
    clr_ex();
    // plain stall holds for two cycles
    stall = 1;
    push("pc", 32'h24); step();
    push("pc", 32'h24); step();
    stall = 0;
    // aliasing: 0x0 then 0x80 share idx 0
    set_ex(0, 32'h0, 32'h200, 1, 1, 32'h200);
    push("redirect", 0); push("gs_we", 0); settle();
    push("pc", 32'h28); step();
    set_ex(0, 32'h80, 32'h300, 1, 1, 32'h300);
    push("redirect", 0); settle();
    push("pc", 32'h2C); step();
    // target mismatch redirect to 0xFFFFFFFF, low bits forced to zero
    set_ex(0, 32'h60, 32'hFFFF_FFFF, 1, 1, 32'h300);
    push("redirect", 1); settle();
    push("pc", 32'hFFFF_FFFC); push("cnt", 5); step();
    clr_ex();
    push("pred_taken", 0); push("pred_target", 0); settle();
    push("pc", 0); push("pred_taken", 0); push("pred_target", 4); step();
    // move to 0x40 then reset mid-cycle
    set_ex(0, 32'h70, 32'h40, 1, 0, 32'h74);
    push("redirect", 1); settle();
    push("pc", 32'h40); push("cnt", 6); step();
    clr_ex();
    #1; rst = 1;
    push("pc", 0); push("cnt", 0); push("pred_taken", 0); push("pred_target", 4); settle();
    #1; rst = 0;
    push("pc", 4); step();
    push("pc", 8); step();
    push("pc", 32'hC); step();
    push("pc", 32'h10); step();
    push("pred_taken", 0); push("pred_target", 32'h14); settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
